// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: schedules SPI bursts from two requesters onto one byte-level
// SPI master core. Round-robin arbitration, per-requester length, divisor and
// mode, slave-select setup/hold/gap timing.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   req[1:0]                  per-requester burst request (level)
//   len[15:0]                 burst length minus 1, 8 bits per requester
//   dvsr[31:0]                SCK half-period divisor, 16 bits per requester
//   cpol[1:0], cpha[1:0]      SPI mode per requester
//   tx_data[2*DW-1:0]         next TX byte per requester
//   gnt[1:0]                  one-hot grant pulse
//   tx_ready[1:0]             tx_data slice consumed this cycle
//   rx_data[DW-1:0]           last received byte
//   rx_valid[1:0]             rx_data valid for requester i
//   done[1:0]                 burst finished pulse
//   busy                      scheduler not idle
//   ss_n[1:0]                 active-low slave selects
//   core_*                    handshake with the SPI master core
module spi_xfer_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [1:0]              req,
  input  logic [15:0]             len,
  input  logic [31:0]             dvsr,
  input  logic [1:0]              cpol,
  input  logic [1:0]              cpha,
  input  logic [2*DATA_WIDTH-1:0] tx_data,
  output logic [1:0]              gnt,
  output logic [1:0]              tx_ready,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic [1:0]              rx_valid,
  output logic [1:0]              done,
  output logic                    busy,
  output logic [1:0]              ss_n,
  output logic [DATA_WIDTH-1:0]   core_din,
  output logic                    core_start,
  output logic                    core_cpol,
  output logic                    core_cpha,
  output logic [15:0]             core_dvsr,
  input  logic [DATA_WIDTH-1:0]   core_dout,
  input  logic                    core_done_tick,
  input  logic                    core_ready
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] HOLD_PRE   = TW'(HOLD_CYC - 2);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
  localparam bit            HOLD_ONE   = (HOLD_CYC == 1);

  typedef enum logic [2:0] {IDLE, ARM, SETUP, XFER, WAIT, HOLD, GAP} state_t;

  state_t                  state;
  logic                    sel;       // index of the requester owning the burst
  logic                    last_gnt;  // index of the previous winner
  logic [7:0]              len_q;
  logic [7:0]              byte_cnt;
  logic [TW-1:0]           tmr;
  logic                    win;
  logic [1:0]              sel_oh;
  logic [DATA_WIDTH-1:0]   tx_sel;

  // Round-robin: a sole requester wins, a tie goes to the one not granted last
  always_comb win = (req == 2'b11) ? ~last_gnt : req[1];

  assign sel_oh = sel ? 2'b10 : 2'b01;
  assign tx_sel = sel ? tx_data[2*DATA_WIDTH-1:DATA_WIDTH] : tx_data[DATA_WIDTH-1:0];

  // Start is decoded from the registered state so the core is launched in the
  // same cycle core_ready is seen in XFER; it can never appear in another state.
  assign core_start = (state == XFER) && core_ready;
  assign tx_ready   = {2{core_start}} & sel_oh;

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last_gnt  <= 1'b1;
      len_q     <= '0;
      byte_cnt  <= '0;
      tmr       <= '0;
      gnt       <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      done      <= '0;
      busy      <= 1'b0;
      ss_n      <= 2'b11;
      core_din  <= '0;
      core_cpol <= 1'b0;
      core_cpha <= 1'b0;
      core_dvsr <= '0;
    end else begin
      gnt      <= '0;
      rx_valid <= '0;
      done     <= '0;
      // Track the owner's TX slice; the requester holds it until tx_ready
      if (state != IDLE) core_din <= tx_sel;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            sel       <= win;
            last_gnt  <= win;
            gnt       <= win ? 2'b10 : 2'b01;
            len_q     <= win ? len[15:8] : len[7:0];
            core_dvsr <= win ? dvsr[31:16] : dvsr[15:0];
            core_cpol <= cpol[win];
            core_cpha <= cpha[win];
            byte_cnt  <= '0;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        // One cycle with selects high so SCK settles to the new idle level
        ARM: begin
          ss_n  <= ~sel_oh;
          tmr   <= '0;
          state <= SETUP;
        end
        SETUP: begin
          if (tmr == SETUP_LAST) state <= XFER;
          else                   tmr   <= tmr + TW'(1);
        end
        XFER: begin
          if (core_ready) state <= WAIT;
        end
        WAIT: begin
          if (core_done_tick) begin
            rx_data  <= core_dout;
            rx_valid <= sel_oh;
            if (byte_cnt == len_q) begin
              tmr   <= '0;
              state <= HOLD;
              if (HOLD_ONE) done <= sel_oh;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              state    <= XFER;
            end
          end
        end
        // done is registered one cycle early so it lands in the last HOLD cycle
        HOLD: begin
          if (tmr == HOLD_LAST) begin
            ss_n  <= 2'b11;
            tmr   <= '0;
            state <= GAP;
          end else begin
            tmr <= tmr + TW'(1);
            if (tmr == HOLD_PRE) done <= sel_oh;
          end
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
